// File: rtl/mem_3r1w_sync_synth_pkg.sv
// mem_3r1w_sync_synth_pkg: shared helpers for the 3-read/1-write synchronous RAM
package mem_3r1w_sync_synth_pkg;
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned els);
    return addr < els;
  endfunction
endpackage

// File: rtl/mem_3r1w_sync_synth_read_port.sv
// mem_sync_read_port: one registered-address read port over a shared word array
// ports: clk_i, reset_i, v_i (read enable), addr_i (read address), mem_i (shared array), data_o (read data)
module mem_sync_read_port
  import mem_3r1w_sync_synth_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 66,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       mem_i [els_p],
  output logic [width_p-1:0]       data_o
);
  logic [addr_width_lp-1:0] r_addr;
  logic                     r_read;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_addr <= '0;
      r_read <= 1'b0;
    end else if (v_i) begin
      r_addr <= addr_i;
      r_read <= 1'b1;
    end
  end
  // Output follows the array live, so later writes to the held address show through.
  assign data_o = (r_read && addr_in_range(32'(r_addr), els_p)) ? mem_i[r_addr] : '0;
endmodule

// File: rtl/mem_3r1w_sync_synth.sv
// mem_3r1w_sync_synth: synchronous RAM, one write port, three 1-cycle-latency read ports
// ports: clk_i, reset_i, w_v_i/w_addr_i/w_data_i (write), rN_v_i/rN_addr_i/rN_data_o for N=0..2 (reads)
// optional: BSG_MEM_CHECKS_EN enables simulation-only usage checks
module mem_3r1w_sync_synth
  import mem_3r1w_sync_synth_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 66,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  output logic [width_p-1:0]       r0_data_o,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [width_p-1:0]       r1_data_o,
  input  logic                     r2_v_i,
  input  logic [addr_width_lp-1:0] r2_addr_i,
  output logic [width_p-1:0]       r2_data_o
);
  logic [width_p-1:0]       r_mem [els_p];
  logic [2:0]               w_rv;
  logic [addr_width_lp-1:0] w_raddr [3];
  logic [width_p-1:0]       w_rdata [3];
  assign w_rv = {r2_v_i, r1_v_i, r0_v_i};
  assign w_raddr[0] = r0_addr_i;
  assign w_raddr[1] = r1_addr_i;
  assign w_raddr[2] = r2_addr_i;
  assign r0_data_o = w_rdata[0];
  assign r1_data_o = w_rdata[1];
  assign r2_data_o = w_rdata[2];
  always_ff @(posedge clk_i) begin
    if (w_v_i && addr_in_range(32'(w_addr_i), els_p)) r_mem[w_addr_i] <= w_data_i;
  end
  for (genvar i = 0; i < 3; i++) begin : g_rd
    mem_sync_read_port #(
      .width_p(width_p),
      .els_p(els_p),
      .addr_width_lp(addr_width_lp)
    ) u_port (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .v_i(w_rv[i]),
      .addr_i(w_raddr[i]),
      .mem_i(r_mem),
      .data_o(w_rdata[i])
    );
  end
`ifdef BSG_MEM_CHECKS_EN
  initial $display("mem_3r1w_sync_synth: width_p=%0d els_p=%0d read_write_same_addr_p=%0d",
                   width_p, els_p, read_write_same_addr_p);
  always @(negedge clk_i) begin
    if (w_v_i) begin
      if (!addr_in_range(32'(w_addr_i), els_p))
        $error("mem_3r1w_sync_synth: write address %0d out of range", w_addr_i);
      for (int p = 0; p < 3; p++)
        if (read_write_same_addr_p == 0 && w_rv[p] && w_raddr[p] == w_addr_i)
          $error("mem_3r1w_sync_synth: port %0d reads address %0d being written", p, w_addr_i);
    end
  end
`else
`endif
endmodule

// File: tb/tb_mem_3r1w_sync_synth.sv
// tb_mem_3r1w_sync_synth: randomized self-checking bench against an array-based reference model
module tb_mem_3r1w_sync_synth;
  localparam int W = 32;
  localparam int E = 66;
  localparam int A = 7;
  logic         clk = 1'b0;
  logic         reset_i = 1'b0;
  logic         w_v_i = 1'b0;
  logic [A-1:0] w_addr_i = '0;
  logic [W-1:0] w_data_i = '0;
  logic [2:0]   rv = '0;
  logic [A-1:0] ra [3] = '{default: '0};
  logic [W-1:0] r0_data_o, r1_data_o, r2_data_o;
  logic [W-1:0] m_mem [E];
  int           m_addr [3];
  bit           m_rd [3];
  int           checks = 0;
  int           errors = 0;

  mem_3r1w_sync_synth #(
    .width_p(W),
    .els_p(E),
    .read_write_same_addr_p(1)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .w_v_i(w_v_i),
    .w_addr_i(w_addr_i),
    .w_data_i(w_data_i),
    .r0_v_i(rv[0]),
    .r0_addr_i(ra[0]),
    .r0_data_o(r0_data_o),
    .r1_v_i(rv[1]),
    .r1_addr_i(ra[1]),
    .r1_data_o(r1_data_o),
    .r2_v_i(rv[2]),
    .r2_addr_i(ra[2]),
    .r2_data_o(r2_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_rd(input int p);
    return (!m_rd[p] || m_addr[p] >= E) ? '0 : m_mem[m_addr[p]];
  endfunction

  function automatic logic [W-1:0] act_rd(input int p);
    return (p == 0) ? r0_data_o : (p == 1) ? r1_data_o : r2_data_o;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (w_v_i && int'(w_addr_i) < E) m_mem[w_addr_i] = w_data_i;
    for (int p = 0; p < 3; p++) begin
      if (reset_i) begin
        m_addr[p] = 0;
        m_rd[p] = 0;
      end else if (rv[p]) begin
        m_addr[p] = int'(ra[p]);
        m_rd[p] = 1;
      end
    end
    #1;
    reset_i = 1'b0;
    w_v_i = 1'b0;
    rv = '0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    w_v_i = 1'b1;
    w_addr_i = A'(a);
    w_data_i = d;
  endtask

  task automatic rd(input int p, input int a);
    rv[p] = 1'b1;
    ra[p] = A'(a);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b1;
    rd(0, 1); rd(1, 2); rd(2, 3);
    tick();
    tick();
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (act_rd(p) !== '0) begin
        errors++;
        $display("FAIL reset port%0d got=%h exp=0", p, act_rd(p));
      end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < E; a++) begin
      wr(a, $urandom);
      tick();
    end
  endtask

  task automatic test_basic();
    wr(5, 32'hDEADBEEF);
    tick();
    rd(0, 5);
    tick();
    checks++;
    if (r0_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read got=%h exp=deadbeef", r0_data_o);
    end
    wr(0, 32'h11); tick();
    wr(1, 32'h22); tick();
    wr(65, 32'h33); tick();
    rd(0, 0); rd(1, 1); rd(2, 65);
    tick();
    checks++;
    if (r0_data_o !== 32'h11 || r1_data_o !== 32'h22 || r2_data_o !== 32'h33) begin
      errors++;
      $display("FAIL three_ports got=%h/%h/%h exp=11/22/33", r0_data_o, r1_data_o, r2_data_o);
    end
    rd(0, 65); rd(1, 65); rd(2, 65);
    tick();
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (act_rd(p) !== 32'h33) begin
        errors++;
        $display("FAIL same_addr_all port%0d got=%h exp=33", p, act_rd(p));
      end
    end
  endtask

  task automatic test_hold();
    wr(7, 32'hA5);
    tick();
    rd(1, 7);
    tick();
    checks++;
    if (r1_data_o !== 32'hA5) begin
      errors++;
      $display("FAIL hold_initial got=%h exp=a5", r1_data_o);
    end
    rd(1, 9);
    wr(7, 32'h5A);
    rv[1] = 1'b0;
    tick();
    checks++;
    if (r1_data_o !== 32'h5A) begin
      errors++;
      $display("FAIL hold_update got=%h exp=5a", r1_data_o);
    end
  endtask

  task automatic test_same_addr();
    wr(3, 32'h1234);
    rd(2, 3);
    tick();
    checks++;
    if (r2_data_o !== 32'h1234) begin
      errors++;
      $display("FAIL write_first got=%h exp=1234", r2_data_o);
    end
  endtask

  task automatic test_out_of_range();
    wr(70, 32'hFFFF_0000);
    rd(0, 70);
    tick();
    checks++;
    if (r0_data_o !== '0) begin
      errors++;
      $display("FAIL oor_read got=%h exp=0", r0_data_o);
    end
    for (int a = 0; a < E; a++) begin
      rd(0, a);
      tick();
      checks++;
      if (r0_data_o !== exp_rd(0)) begin
        errors++;
        $display("FAIL oor_sweep addr=%0d got=%h exp=%h", a, r0_data_o, exp_rd(0));
      end
    end
  endtask

  task automatic test_reset_read_drop();
    reset_i = 1'b1;
    rd(0, 5); rd(1, 7); rd(2, 3);
    wr(10, 32'hCAFE_F00D);
    tick();
    tick();
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (act_rd(p) !== '0) begin
        errors++;
        $display("FAIL reset_drop port%0d got=%h exp=0", p, act_rd(p));
      end
    end
    rd(0, 10); rd(1, 7); rd(2, 3);
    tick();
    checks++;
    if (r0_data_o !== 32'hCAFE_F00D || r1_data_o !== 32'h5A || r2_data_o !== 32'h1234) begin
      errors++;
      $display("FAIL after_reset got=%h/%h/%h exp=cafef00d/5a/1234", r0_data_o, r1_data_o, r2_data_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 69), $urandom);
      for (int p = 0; p < 3; p++) if ($urandom_range(0, 2) != 0) rd(p, $urandom_range(0, 69));
      reset_i = ($urandom_range(0, 39) == 0);
      tick();
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (act_rd(p) !== exp_rd(p)) begin
          errors++;
          $display("FAIL random cyc=%0d port%0d got=%h exp=%h", c, p, act_rd(p), exp_rd(p));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_hold();
    test_same_addr();
    test_out_of_range();
    test_reset_read_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
